// File: rtl/lcd_pkg.sv
// Shared frame-buffer types and geometry for the LCD
// scan-out path, drawing engine and BRAM arbiter.
package lcd_pkg;

  localparam int H_ACTIVE     = 480;
  localparam int V_ACTIVE     = 272;
  localparam int FB_DEPTH     = H_ACTIVE * V_ACTIVE;
  localparam int ADDR_W       = 17;
  localparam int DATA_W       = 16;
  localparam int STARVE_LIMIT = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_DRW  = 2'd2
  } owner_t;

  // Tag that travels alongside each issued BRAM read.
  typedef struct packed {
    logic   vld;
    owner_t own;
    logic   err;
  } rd_tag_t;

  function automatic logic in_fb(
    input logic [ADDR_W-1:0] a
  );
    return a < ADDR_W'(FB_DEPTH);
  endfunction

endpackage

// File: rtl/fb_rd_return.sv
// Two-stage read tag pipe: steers BRAM read data back
// to the requester that issued the read.
module fb_rd_return
  import lcd_pkg::*;
#(
  parameter int DW = DATA_W
) (
  input  logic          clk,
  input  logic          rstn,
  input  rd_tag_t       tag_i,
  input  logic [DW-1:0] bram_rdata_i,
  output logic          disp_rvalid_o,
  output logic [DW-1:0] disp_rdata_o,
  output logic          drw_rvalid_o,
  output logic [DW-1:0] drw_rdata_o
);

  rd_tag_t       s1_q, s1_d;
  rd_tag_t       s2_q, s2_d;
  logic [DW-1:0] rd_data;

  // Advance tags one stage per clock.
  always_comb begin
    s1_d = tag_i;
    s2_d = s1_q;
  end

  // Tag registers; reset flushes any read in flight.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  // Error slots return zero instead of BRAM data.
  always_comb begin
    rd_data = s2_q.err ? '0 : bram_rdata_i;
    disp_rvalid_o = s2_q.vld &
                    (s2_q.own == OWN_DISP);
    drw_rvalid_o  = s2_q.vld &
                    (s2_q.own == OWN_DRW);
    disp_rdata_o  = disp_rvalid_o ? rd_data : '0;
    drw_rdata_o   = drw_rvalid_o ? rd_data : '0;
  end

endmodule

// File: rtl/lcd_fb_arbiter.sv
// Frame-buffer BRAM arbiter: display prefetch first,
// drawing engine guaranteed progress by a starve timer.
module lcd_fb_arbiter
  import lcd_pkg::*;
#(
  parameter int H_ACTIVE     = lcd_pkg::H_ACTIVE,
  parameter int V_ACTIVE     = lcd_pkg::V_ACTIVE,
  parameter int ADDR_W       = lcd_pkg::ADDR_W,
  parameter int DATA_W       = lcd_pkg::DATA_W,
  parameter int STARVE_LIMIT = lcd_pkg::STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  input  logic              disp_urgent,
  output logic              disp_gnt,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              drw_req,
  input  logic              drw_we,
  input  logic [ADDR_W-1:0] drw_addr,
  input  logic [DATA_W-1:0] drw_wdata,
  output logic              drw_gnt,
  output logic              drw_rvalid,
  output logic [DATA_W-1:0] drw_rdata,
  output logic              addr_err,
  output logic              drw_forced,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wdata,
  input  logic [DATA_W-1:0] bram_rdata
);

  localparam int CNT_W =
    $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT =
    CNT_W'(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0] DEPTH =
    ADDR_W'(H_ACTIVE * V_ACTIVE);

  logic [CNT_W-1:0]  wait_q, wait_d;
  logic              en_q, en_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;
  logic              forced_q, forced_d;

  logic              force_c;
  logic              dgnt_c;
  logic              wgnt_c;
  logic              any_gnt;
  logic              wr_c;
  logic              oob_c;
  logic [ADDR_W-1:0] sel_addr;
  rd_tag_t           tag_d;

  // Grant decision: forced draw, then display, then draw.
  always_comb begin
    force_c = rstn & drw_req & ~disp_urgent &
              (wait_q == LIMIT);
    dgnt_c  = rstn & ~force_c & disp_req;
    wgnt_c  = rstn &
              (force_c | (drw_req & ~disp_req));
    any_gnt = dgnt_c | wgnt_c;
    wr_c    = wgnt_c & drw_we;
    sel_addr = wgnt_c ? drw_addr : disp_addr;
    oob_c   = any_gnt & (sel_addr >= DEPTH);
  end

  // Starve counter: counts denied draw cycles, saturating.
  always_comb begin
    wait_d = wait_q;
    if (!drw_req || wgnt_c) begin
      wait_d = '0;
    end else if (wait_q != LIMIT) begin
      wait_d = wait_q + 1'b1;
    end
  end

  // Command next-state; out-of-range slots stay disabled.
  always_comb begin
    en_d     = any_gnt & ~oob_c;
    we_d     = wr_c & ~oob_c;
    addr_d   = any_gnt ? sel_addr : addr_q;
    wdata_d  = wgnt_c ? drw_wdata : wdata_q;
    err_d    = oob_c;
    forced_d = force_c;
  end

  // Read tag launched with each granted read.
  always_comb begin
    tag_d     = '0;
    tag_d.vld = dgnt_c | (wgnt_c & ~drw_we);
    tag_d.err = oob_c;
    unique case (1'b1)
      dgnt_c:           tag_d.own = OWN_DISP;
      wgnt_c & ~drw_we: tag_d.own = OWN_DRW;
      default:          tag_d.own = OWN_NONE;
    endcase
  end

  // Command and status registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wait_q   <= '0;
      en_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      forced_q <= 1'b0;
    end else begin
      wait_q   <= wait_d;
      en_q     <= en_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      forced_q <= forced_d;
    end
  end

  fb_rd_return #(
    .DW (DATA_W)
  ) u_ret (
    .clk           (clk),
    .rstn          (rstn),
    .tag_i         (tag_d),
    .bram_rdata_i  (bram_rdata),
    .disp_rvalid_o (disp_rvalid),
    .disp_rdata_o  (disp_rdata),
    .drw_rvalid_o  (drw_rvalid),
    .drw_rdata_o   (drw_rdata)
  );

  assign disp_gnt   = dgnt_c;
  assign drw_gnt    = wgnt_c;
  assign bram_en    = en_q;
  assign bram_we    = we_q;
  assign bram_addr  = addr_q;
  assign bram_wdata = wdata_q;
  assign addr_err   = err_q;
  assign drw_forced = forced_q;

endmodule

// File: tb/tb_lcd_fb_arbiter.sv
// Directed bench for lcd_fb_arbiter with a
// behavioural 1-cycle-latency BRAM model.
module tb_lcd_fb_arbiter;

  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;

  logic        clk = 1'b0;
  logic        rstn;
  logic        disp_req;
  logic [16:0] disp_addr;
  logic        disp_urgent;
  logic        disp_gnt;
  logic        disp_rvalid;
  logic [15:0] disp_rdata;
  logic        drw_req;
  logic        drw_we;
  logic [16:0] drw_addr;
  logic [15:0] drw_wdata;
  logic        drw_gnt;
  logic        drw_rvalid;
  logic [15:0] drw_rdata;
  logic        addr_err;
  logic        drw_forced;
  logic        bram_en;
  logic        bram_we;
  logic [16:0] bram_addr;
  logic [15:0] bram_wdata;
  logic [15:0] bram_rdata = 16'h0;

  logic [15:0] mem [0:131071];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lcd_fb_arbiter dut (
    .clk         (clk),
    .rstn        (rstn),
    .disp_req    (disp_req),
    .disp_addr   (disp_addr),
    .disp_urgent (disp_urgent),
    .disp_gnt    (disp_gnt),
    .disp_rvalid (disp_rvalid),
    .disp_rdata  (disp_rdata),
    .drw_req     (drw_req),
    .drw_we      (drw_we),
    .drw_addr    (drw_addr),
    .drw_wdata   (drw_wdata),
    .drw_gnt     (drw_gnt),
    .drw_rvalid  (drw_rvalid),
    .drw_rdata   (drw_rdata),
    .addr_err    (addr_err),
    .drw_forced  (drw_forced),
    .bram_en     (bram_en),
    .bram_we     (bram_we),
    .bram_addr   (bram_addr),
    .bram_wdata  (bram_wdata),
    .bram_rdata  (bram_rdata)
  );

  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) mem[bram_addr] <= bram_wdata;
      else bram_rdata <= mem[bram_addr];
    end
  end

  typedef struct {
    logic        dreq;
    logic [16:0] daddr;
    logic        wreq;
    logic        wwe;
    logic [16:0] waddr;
    logic [15:0] wdata;
    logic        e_dg;
    logic        e_wg;
    logic        e_en;
    logic        e_err;
    logic        e_drv;
    logic [15:0] e_drd;
    logic        e_wrv;
    logic [15:0] e_wrd;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(
    input logic dreq, input logic [16:0] daddr,
    input logic wreq, input logic wwe,
    input logic [16:0] waddr, input logic [15:0] wdata,
    input logic dg, input logic wg,
    input logic en, input logic err,
    input logic drv, input logic [15:0] drd,
    input logic wrv, input logic [15:0] wrd
  );
    vec_t v;
    v.dreq = dreq; v.daddr = daddr;
    v.wreq = wreq; v.wwe = wwe;
    v.waddr = waddr; v.wdata = wdata;
    v.e_dg = dg; v.e_wg = wg;
    v.e_en = en; v.e_err = err;
    v.e_drv = drv; v.e_drd = drd;
    v.e_wrv = wrv; v.e_wrd = wrd;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    disp_req = 1'b0; disp_addr = '0;
    disp_urgent = 1'b0;
    drw_req = 1'b0; drw_we = 1'b0;
    drw_addr = '0; drw_wdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++)
      mem[i] = 16'h0100 + 16'(i);

    //       dreq daddr  wreq we waddr      wdata
    //       dg wg en err  drv drd  wrv wrd
    tbl[0]  = mk(Y,17'd0, N,N,17'd0,16'h0,
                 Y,N,N,N, N,16'h0, N,16'h0);
    tbl[1]  = mk(Y,17'd1, N,N,17'd0,16'h0,
                 Y,N,Y,N, N,16'h0, N,16'h0);
    tbl[2]  = mk(Y,17'd2, N,N,17'd0,16'h0,
                 Y,N,Y,N, Y,16'h0100, N,16'h0);
    tbl[3]  = mk(N,17'd0, N,N,17'd0,16'h0,
                 N,N,Y,N, Y,16'h0101, N,16'h0);
    tbl[4]  = mk(N,17'd0, N,N,17'd0,16'h0,
                 N,N,N,N, Y,16'h0102, N,16'h0);
    tbl[5]  = mk(N,17'd0, Y,Y,17'd7,16'h07E0,
                 N,Y,N,N, N,16'h0, N,16'h0);
    tbl[6]  = mk(N,17'd0, Y,N,17'd7,16'h0,
                 N,Y,Y,N, N,16'h0, N,16'h0);
    tbl[7]  = mk(N,17'd0, N,N,17'd0,16'h0,
                 N,N,Y,N, N,16'h0, N,16'h0);
    tbl[8]  = mk(N,17'd0, N,N,17'd0,16'h0,
                 N,N,N,N, N,16'h0, Y,16'h07E0);
    tbl[9]  = mk(N,17'd0, Y,N,17'd130560,16'h0,
                 N,Y,N,N, N,16'h0, N,16'h0);
    tbl[10] = mk(N,17'd0, N,N,17'd0,16'h0,
                 N,N,N,Y, N,16'h0, N,16'h0);
    tbl[11] = mk(N,17'd0, N,N,17'd0,16'h0,
                 N,N,N,N, N,16'h0, Y,16'h0);
    tbl[12] = mk(Y,17'd3, Y,N,17'd4,16'h0,
                 Y,N,N,N, N,16'h0, N,16'h0);
    tbl[13] = mk(N,17'd0, Y,N,17'd4,16'h0,
                 N,Y,Y,N, N,16'h0, N,16'h0);
    tbl[14] = mk(N,17'd0, N,N,17'd0,16'h0,
                 N,N,Y,N, Y,16'h0103, N,16'h0);
    tbl[15] = mk(N,17'd0, N,N,17'd0,16'h0,
                 N,N,N,N, N,16'h0, Y,16'h0104);

    // Reset state.
    idle_in();
    rstn = 1'b0;
    disp_req = 1'b1;
    drw_req = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("rst_dgnt", disp_gnt, 0);
    chk("rst_wgnt", drw_gnt, 0);
    chk("rst_en", bram_en, 0);
    chk("rst_we", bram_we, 0);
    chk("rst_addr", bram_addr, 0);
    chk("rst_wdata", bram_wdata, 0);
    chk("rst_err", addr_err, 0);
    chk("rst_forced", drw_forced, 0);
    chk("rst_drv", disp_rvalid, 0);
    chk("rst_wrv", drw_rvalid, 0);
    step();
    idle_in();
    rstn = 1'b1;
    step();
    step();

    // Table-driven cycle vectors.
    for (int i = 0; i < 16; i++) begin
      disp_req  = tbl[i].dreq;
      disp_addr = tbl[i].daddr;
      drw_req   = tbl[i].wreq;
      drw_we    = tbl[i].wwe;
      drw_addr  = tbl[i].waddr;
      drw_wdata = tbl[i].wdata;
      @(negedge clk);
      chk($sformatf("v%0d_dgnt", i), disp_gnt, tbl[i].e_dg);
      chk($sformatf("v%0d_wgnt", i), drw_gnt, tbl[i].e_wg);
      chk($sformatf("v%0d_en", i), bram_en, tbl[i].e_en);
      chk($sformatf("v%0d_err", i), addr_err, tbl[i].e_err);
      chk($sformatf("v%0d_drv", i), disp_rvalid, tbl[i].e_drv);
      chk($sformatf("v%0d_drd", i), disp_rdata, tbl[i].e_drd);
      chk($sformatf("v%0d_wrv", i), drw_rvalid, tbl[i].e_wrv);
      chk($sformatf("v%0d_wrd", i), drw_rdata, tbl[i].e_wrd);
      step();
    end
    idle_in();
    step();

    // Reset while a display read is in flight.
    disp_req = 1'b1;
    disp_addr = 17'd1;
    @(negedge clk);
    chk("rmr_gnt", disp_gnt, 1);
    step();
    rstn = 1'b0;
    @(negedge clk);
    chk("rmr_dgnt_low", disp_gnt, 0);
    chk("rmr_wgnt_low", drw_gnt, 0);
    step();
    rstn = 1'b1;
    disp_req = 1'b0;
    @(negedge clk);
    chk("rmr_drv", disp_rvalid, 0);
    chk("rmr_en", bram_en, 0);
    chk("rmr_addr", bram_addr, 0);
    chk("rmr_err", addr_err, 0);
    step();
    @(negedge clk);
    chk("rmr_drv2", disp_rvalid, 0);
    step();

    // Contention: draw forced after 8 denied cycles.
    disp_req = 1'b1;
    disp_addr = 17'd0;
    drw_req = 1'b1;
    drw_we = 1'b1;
    drw_addr = 17'd5;
    drw_wdata = 16'hF800;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      chk($sformatf("ct%0d_wgnt", k), drw_gnt,
          (k == 8) ? 1 : 0);
      chk($sformatf("ct%0d_dgnt", k), disp_gnt,
          (k == 8) ? 0 : 1);
      step();
    end
    drw_req = 1'b0;
    @(negedge clk);
    chk("ct_forced", drw_forced, 1);
    chk("ct_we", bram_we, 1);
    chk("ct_addr", bram_addr, 5);
    chk("ct_wdata", bram_wdata, 16'hF800);
    step();
    disp_req = 1'b0;
    @(negedge clk);
    chk("ct_forced_pulse", drw_forced, 0);
    step();
    step();
    chk("ct_mem5", mem[5], 16'hF800);

    // Urgent display blocks forced draw grants.
    disp_req = 1'b1;
    disp_urgent = 1'b1;
    drw_req = 1'b1;
    drw_we = 1'b1;
    drw_addr = 17'd6;
    drw_wdata = 16'h1234;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk($sformatf("ur%0d_wgnt", k), drw_gnt, 0);
      step();
    end
    disp_urgent = 1'b0;
    @(negedge clk);
    chk("ur_rel_wgnt", drw_gnt, 1);
    chk("ur_rel_dgnt", disp_gnt, 0);
    step();
    idle_in();
    @(negedge clk);
    chk("ur_forced", drw_forced, 1);
    step();
    step();
    chk("ur_mem6", mem[6], 16'h1234);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
